// File: rtl/riscv_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | riscv_ex_stage: RV32I execute stage - ALU, operand select, EX/MEM reg.   |
// | Optional macro EX_BRANCH_CMP_EN enables the funct3 branch comparator.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module riscv_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  input  logic        alu_src,
  input  logic [1:0]  alu_op,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic        valid_in,
  input  logic        stall,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic        branch_taken,
  output logic [31:0] mem_alu_result,
  output logic        mem_zero,
  output logic [31:0] mem_rs2_data,
  output logic        mem_valid
);

  localparam logic [1:0] C_OP_ADD   = 2'b00;
  localparam logic [1:0] C_OP_SUB   = 2'b01;
  localparam logic [1:0] C_OP_RTYPE = 2'b10;
  localparam logic [1:0] C_OP_ITYPE = 2'b11;

  logic [31:0] w_op_a;
  logic [31:0] w_op_b;
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [31:0] w_result;
  logic [4:0]  w_shamt;
  logic        w_lt_s;
  logic        w_lt_u;
  logic        w_eq;
  logic        w_alt;
  logic        w_branch;
  logic        w_unused;

  logic [31:0] r_alu_result;
  logic        r_zero;
  logic [31:0] r_rs2_data;
  logic        r_valid;

  assign w_op_a   = rs1_data;
  assign w_op_b   = alu_src ? imm : rs2_data;
  assign w_shamt  = w_op_b[4:0];
  assign w_sum    = w_op_a + w_op_b;
  assign w_diff   = w_op_a - w_op_b;
  assign w_lt_s   = $signed(w_op_a) < $signed(w_op_b);
  assign w_lt_u   = w_op_a < w_op_b;
  assign w_eq     = (w_op_a == w_op_b);
  assign w_alt    = funct7[5];
  assign w_unused = &{1'b0, funct7[6], funct7[4:0]};

  always_comb begin
    w_result = w_sum;
    case (alu_op)
      C_OP_ADD: w_result = w_sum;
      C_OP_SUB: w_result = w_diff;
      C_OP_RTYPE, C_OP_ITYPE: begin
        case (funct3)
          // Only R-type may turn funct3=000 into SUB; ADDI ignores funct7.
          3'b000:  w_result = (alu_op == C_OP_RTYPE && w_alt) ? w_diff : w_sum;
          3'b001:  w_result = w_op_a << w_shamt;
          3'b010:  w_result = {31'd0, w_lt_s};
          3'b011:  w_result = {31'd0, w_lt_u};
          3'b100:  w_result = w_op_a ^ w_op_b;
          3'b101:  w_result = w_alt ? 32'($signed(w_op_a) >>> w_shamt)
                                    : (w_op_a >> w_shamt);
          3'b110:  w_result = w_op_a | w_op_b;
          default: w_result = w_op_a & w_op_b;
        endcase
      end
      default: w_result = w_sum;
    endcase
  end

`ifdef EX_BRANCH_CMP_EN
  always_comb begin
    w_branch = 1'b0;
    if (alu_op == C_OP_SUB) begin
      case (funct3)
        3'b000:  w_branch = w_eq;
        3'b001:  w_branch = !w_eq;
        3'b100:  w_branch = w_lt_s;
        3'b101:  w_branch = !w_lt_s;
        3'b110:  w_branch = w_lt_u;
        3'b111:  w_branch = !w_lt_u;
        default: w_branch = 1'b0;
      endcase
    end
  end
`else
  assign w_branch = 1'b0 & w_eq;
`endif

  assign alu_result   = w_result;
  assign zero         = (w_result == 32'd0);
  assign branch_taken = w_branch;

  // A bubble (valid_in=0) clears only the valid bit; the data stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_result <= '0;
      r_zero       <= 1'b0;
      r_rs2_data   <= '0;
      r_valid      <= 1'b0;
    end else if (!stall) begin
      r_valid <= valid_in;
      if (valid_in) begin
        r_alu_result <= w_result;
        r_zero       <= (w_result == 32'd0);
        r_rs2_data   <= rs2_data;
      end
    end
  end

  assign mem_alu_result = r_alu_result;
  assign mem_zero       = r_zero;
  assign mem_rs2_data   = r_rs2_data;
  assign mem_valid      = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_riscv_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_riscv_ex_stage: self-checking bench for riscv_ex_stage.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_riscv_ex_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        valid_in;
  logic        stall;
  logic [31:0] alu_result;
  logic        zero;
  logic        branch_taken;
  logic [31:0] mem_alu_result;
  logic        mem_zero;
  logic [31:0] mem_rs2_data;
  logic        mem_valid;

  int tests;
  int failures;

  // Expected EX/MEM register contents
  logic [31:0] exp_res;
  logic        exp_zero;
  logic [31:0] exp_rs2;
  logic        exp_valid;

  riscv_ex_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .imm            (imm),
    .alu_src        (alu_src),
    .alu_op         (alu_op),
    .funct3         (funct3),
    .funct7         (funct7),
    .valid_in       (valid_in),
    .stall          (stall),
    .alu_result     (alu_result),
    .zero           (zero),
    .branch_taken   (branch_taken),
    .mem_alu_result (mem_alu_result),
    .mem_zero       (mem_zero),
    .mem_rs2_data   (mem_rs2_data),
    .mem_valid      (mem_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7);
    int unsigned s;
    logic [31:0] fill;
    s = b % 32;
    if (op == 2'b00) return a + b;
    if (op == 2'b01) return a - b;
    case (f3)
      3'd0: return (op == 2'b10 && f7[5]) ? a - b : a + b;
      3'd1: return a << s;
      3'd2: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: begin
        fill = (f7[5] && a[31]) ? ~(32'hFFFF_FFFF >> s) : 32'd0;
        return (a >> s) | fill;
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic ref_branch(input logic [31:0] a, input logic [31:0] b,
                                      input logic [1:0] op, input logic [2:0] f3);
    logic lts;
    lts = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    if (op != 2'b01) return 1'b0;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return lts;
      3'd5: return !lts;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_mem(input string tag);
    check({tag, ".mem_alu_result"}, mem_alu_result, exp_res);
    check({tag, ".mem_zero"}, {31'd0, mem_zero}, {31'd0, exp_zero});
    check({tag, ".mem_rs2_data"}, mem_rs2_data, exp_rs2);
    check({tag, ".mem_valid"}, {31'd0, mem_valid}, {31'd0, exp_valid});
  endtask

  // Drive one instruction, check the combinational outputs, clock once, check EX/MEM.
  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] im, input logic src, input logic [1:0] op,
                      input logic [2:0] f3, input logic [6:0] f7,
                      input logic vin, input logic stl);
    logic [31:0] opb;
    logic [31:0] er;
    logic        eb;
    rs1_data = a; rs2_data = b; imm = im; alu_src = src;
    alu_op = op; funct3 = f3; funct7 = f7; valid_in = vin; stall = stl;
    #1;
    opb = src ? im : b;
    er  = ref_alu(a, opb, op, f3, f7);
`ifdef EX_BRANCH_CMP_EN
    eb = ref_branch(a, opb, op, f3);
`else
    eb = 1'b0;
`endif
    check({tag, ".alu_result"}, alu_result, er);
    check({tag, ".zero"}, {31'd0, zero}, {31'd0, (er == 32'd0)});
    check({tag, ".branch_taken"}, {31'd0, branch_taken}, {31'd0, eb});
    if (!rst_n) begin
      exp_res = '0; exp_zero = 1'b0; exp_rs2 = '0; exp_valid = 1'b0;
    end else if (!stl) begin
      exp_valid = vin;
      if (vin) begin
        exp_res = er; exp_zero = (er == 32'd0); exp_rs2 = b;
      end
    end
    @(posedge clk);
    #1;
    check_mem(tag);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] ri;
    tests = 0; failures = 0;
    exp_res = '0; exp_zero = 1'b0; exp_rs2 = '0; exp_valid = 1'b0;
    rst_n = 1'b0;
    rs1_data = '0; rs2_data = '0; imm = '0; alu_src = 1'b0;
    alu_op = '0; funct3 = '0; funct7 = '0; valid_in = 1'b1; stall = 1'b0;
    #2;
    check_mem("reset");

    // Directed ALU cases while reset holds the register at zero.
    step("add",   32'd10, 32'd5,  32'd0,  1'b0, 2'b10, 3'b000, 7'h00, 1'b1, 1'b0);
    step("sub",   32'd20, 32'd10, 32'd0,  1'b0, 2'b10, 3'b000, 7'h20, 1'b1, 1'b0);
    step("sub0",  32'd20, 32'd20, 32'd0,  1'b0, 2'b10, 3'b000, 7'h20, 1'b1, 1'b0);
    step("addi",  32'd15, 32'd0,  32'd25, 1'b1, 2'b00, 3'b000, 7'h20, 1'b1, 1'b0);
    step("addi3", 32'd15, 32'd0,  32'd25, 1'b1, 2'b11, 3'b000, 7'h20, 1'b1, 1'b0);
    step("srai",  32'h8000_0000, 32'd0, 32'h404, 1'b1, 2'b11, 3'b101, 7'h20, 1'b1, 1'b0);
    step("slt",   32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 2'b10, 3'b010, 7'h00, 1'b1, 1'b0);
    step("sltu",  32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 2'b10, 3'b011, 7'h00, 1'b1, 1'b0);
    step("blt",   32'hFFFF_FFFD, 32'd2, 32'd0, 1'b0, 2'b01, 3'b100, 7'h00, 1'b1, 1'b0);
    step("bltu",  32'hFFFF_FFFD, 32'd2, 32'd0, 1'b0, 2'b01, 3'b110, 7'h00, 1'b1, 1'b0);

    // Pipeline register sequence.
    #2 rst_n = 1'b1;
    step("pipe_add",   32'd10, 32'd5, 32'd0, 1'b0, 2'b10, 3'b000, 7'h00, 1'b1, 1'b0);
    step("pipe_stall", 32'd7,  32'd9, 32'd0, 1'b0, 2'b10, 3'b000, 7'h00, 1'b1, 1'b1);
    step("pipe_bub",   32'd3,  32'd3, 32'd0, 1'b0, 2'b10, 3'b000, 7'h20, 1'b0, 1'b0);
    step("pipe_zero",  32'd3,  32'd3, 32'd0, 1'b0, 2'b10, 3'b000, 7'h20, 1'b1, 1'b0);

    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      ri = ($urandom_range(0, 1) == 0) ? $urandom : {{20{1'b0}}, 12'($urandom)};
      if ($urandom_range(0, 3) == 0) ra = ra & 32'h0000_00FF;
      step("rand", ra, rb, ri, 1'($urandom), 2'($urandom), 3'($urandom),
           7'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0));
      if (i % 97 == 50) begin
        #2 rst_n = 1'b0;
        #1;
        exp_res = '0; exp_zero = 1'b0; exp_rs2 = '0; exp_valid = 1'b0;
        check_mem("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
`default_nettype wire
